// File: rtl/ahb_slave_mem.sv
// AHB-Lite word-organised memory completer with programmable wait states
// and two-cycle ERROR responses for out-of-range, oversize or misaligned
// transfers.
module ahb_slave_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);

    localparam int                    IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(MEM_DEPTH * 4);
    localparam logic [3:0]            WS_M1 = 4'(WAIT_STATES - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2
    } state_t;

    state_t                 state;
    logic [3:0]             cnt;
    logic [IDX_W-1:0]       dp_idx;
    logic [1:0]             dp_lane;
    logic [1:0]             dp_size;
    logic                   dp_write;

    logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

    logic                   accept;
    logic                   misalign;
    logic                   addr_err;
    logic [IDX_W-1:0]       rd_idx;
    logic [3:0]             strb;
    logic [DATA_WIDTH-1:0]  wr_word;
    logic [DATA_WIDTH-1:0]  rd_word;
    logic                   wr_commit;

    // Burst type and the SEQ/NONSEQ distinction carry no decode meaning here.
    logic unused_ok;
    assign unused_ok = ^{HTRANS[0], HBURST};

    // Address phase is only taken while we are driving ready ourselves, so a
    // stray HREADY during our own stall can never start a second transfer.
    assign accept   = HSEL & HREADY & HTRANS[1] & HREADYOUT;
    assign misalign = (HSIZE == 3'b001 && HADDR[0]) ||
                      (HSIZE == 3'b010 && HADDR[1:0] != 2'b00);
    assign addr_err = (HADDR >= LIMIT) || (HSIZE > 3'b010) || misalign;
    assign rd_idx   = HADDR[IDX_W+1:2];

    assign wr_commit = (state == ST_DATA) && dp_write && !HRESET;

    // Merge HWDATA into the addressed word on the little-endian lanes picked by size/offset.
    always_comb begin
        strb = 4'b0000;
        case (dp_size)
            2'b00:   strb[dp_lane] = 1'b1;
            2'b01:   strb = dp_lane[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
        wr_word = mem[dp_idx];
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) wr_word[8*i +: 8] = HWDATA[8*i +: 8];
        end
    end

    // A read accepted in the same cycle a write commits to that word sees the new data.
    assign rd_word = (state == ST_DATA && dp_write && rd_idx == dp_idx) ? wr_word : mem[rd_idx];

    // Memory array: written only on the completing data-phase edge, never reset.
    always_ff @(posedge HCLK) begin
        if (wr_commit) mem[dp_idx] <= wr_word;
    end

    // Transfer FSM with registered HREADYOUT/HRESP/HRDATA.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= '0;
            dp_idx    <= '0;
            dp_lane   <= 2'b00;
            dp_size   <= 2'b00;
            dp_write  <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= ST_DATA;
                        HREADYOUT <= 1'b1;
                        if (!dp_write) HRDATA <= mem[dp_idx];
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b1;
                end
                default: begin
                    // ST_IDLE, ST_DATA and ST_ERR2 all sit with HREADYOUT=1.
                    if (accept) begin
                        dp_idx   <= rd_idx;
                        dp_lane  <= HADDR[1:0];
                        dp_size  <= HSIZE[1:0];
                        dp_write <= HWRITE;
                        if (addr_err) begin
                            state     <= ST_ERR1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b1;
                            HRDATA    <= '0;
                        end else if (WAIT_STATES > 0) begin
                            state     <= ST_WAIT;
                            cnt       <= WS_M1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b0;
                        end else begin
                            state     <= ST_DATA;
                            HREADYOUT <= 1'b1;
                            HRESP     <= 1'b0;
                            if (!HWRITE) HRDATA <= rd_word;
                        end
                    end else begin
                        state     <= ST_IDLE;
                        HREADYOUT <= 1'b1;
                        HRESP     <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: two instances (0 and 3 wait states) share one
// driven bus; only the instance picked by dsel is selected. Each completed
// data phase is checked against a byte-level memory model and the expected
// response timing.
module tb_ahb_slave_mem;

    localparam int DEPTH = 256;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        bus_sel;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic [1:0]  hro;
    logic [1:0]  hresp;
    logic [31:0] hrd [2];
    int          dsel;

    logic [31:0] model [2][DEPTH];
    xfer_t       seq [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 HCLK = ~HCLK;

    ahb_slave_mem #(.WAIT_STATES(0)) u_dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(bus_sel && dsel == 0), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HWDATA(HWDATA), .HREADY(hro[0]), .HREADYOUT(hro[0]), .HRESP(hresp[0]),
        .HRDATA(hrd[0])
    );

    ahb_slave_mem #(.WAIT_STATES(3)) u_dut3 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(bus_sel && dsel == 1), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HWDATA(HWDATA), .HREADY(hro[1]), .HREADYOUT(hro[1]), .HRESP(hresp[1]),
        .HRDATA(hrd[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (dut %0d, t=%0t)", tag, got, exp, dsel, $time);
        end
    endtask

    function automatic bit exp_err(input xfer_t t);
        return (t.addr >= 32'(DEPTH * 4)) || (t.size > 3'd2) ||
               (t.size == 3'd1 && t.addr[0]) || (t.size == 3'd2 && t.addr[1:0] != 2'b00);
    endfunction

    function automatic void mdl_write(input int d, input xfer_t t);
        int first = int'(t.addr[1:0]);
        int nbytes = 1 << t.size;
        for (int b = first; b < first + nbytes; b++)
            model[d][t.addr[9:2]][8*b +: 8] = t.data[8*b +: 8];
    endfunction

    function automatic xfer_t mk(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                                 input logic [31:0] a, input logic [31:0] dat);
        xfer_t t;
        t.sel = 1'b1; t.trans = tr; t.write = wr; t.size = sz; t.addr = a; t.data = dat;
        return t;
    endfunction

    task automatic drive_idle();
        bus_sel = 1'b0; HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0; HSIZE = 3'd2; HBURST = 3'd0;
    endtask

    // Score one completed data phase against the model and the expected timing.
    task automatic retire(input xfer_t t, input int nw, input int ne, input logic p, input logic [31:0] d);
        if (!(t.sel && t.trans[1])) begin
            chk("noop_stall", nw + ne, 0);
            chk("noop_resp", {31'b0, p}, 0);
        end else if (exp_err(t)) begin
            chk("err_resp", {31'b0, p}, 1);
            chk("err_first_cycles", ne, 1);
            chk("err_wait", nw, 0);
            chk("err_rdata", d, 0);
        end else begin
            chk("ok_resp", {31'b0, p}, 0);
            chk("ok_wait", nw, (dsel == 1) ? 3 : 0);
            if (t.write) mdl_write(dsel, t);
            else chk("rdata", d, model[dsel][t.addr[9:2]]);
        end
    endtask

    // Issue the queued transfers back-to-back: a new address phase goes out
    // in the same cycle the previous data phase completes.
    task automatic run_seq();
        xfer_t       cur;
        bit          have = 0;
        int          idx = 0, nw = 0, ne = 0, guard = 0;
        logic        r, p;
        logic [31:0] d;
        while (have || idx < seq.size()) begin
            @(negedge HCLK);
            r = hro[dsel]; p = hresp[dsel]; d = hrd[dsel];
            if (have) begin
                HWDATA = cur.write ? cur.data : 32'h0;
                if (!r) begin
                    if (p) ne++; else nw++;
                    guard++;
                    if (guard > 20) begin
                        chk("timeout", 32'(guard), 0);
                        have = 0;
                        break;
                    end
                end else begin
                    retire(cur, nw, ne, p, d);
                    have = 0;
                end
            end
            if (!have) begin
                if (idx < seq.size()) begin
                    cur = seq[idx]; idx++;
                    bus_sel = cur.sel; HTRANS = cur.trans; HADDR = cur.addr;
                    HWRITE = cur.write; HSIZE = cur.size; HBURST = 3'd1;
                    have = 1; nw = 0; ne = 0; guard = 0;
                end else begin
                    drive_idle();
                end
            end
        end
        drive_idle();
        seq.delete();
    endtask

    function automatic xfer_t rnd_xfer();
        xfer_t t;
        int r;
        t.sel = ($urandom_range(0, 9) != 0);
        r = $urandom_range(0, 9);
        t.trans = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : {1'b1, 1'($urandom_range(0, 1))};
        t.write = 1'($urandom_range(0, 1));
        t.size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        r = $urandom_range(0, 9);
        if (r == 0)      t.addr = 32'h400 + 32'($urandom_range(0, 1023));
        else if (r < 5)  t.addr = 32'($urandom_range(0, 31));
        else             t.addr = 32'($urandom_range(0, 1023));
        if (t.size <= 3'd2 && $urandom_range(0, 4) != 0)
            t.addr = t.addr & ~((32'd1 << t.size) - 32'd1);
        t.data = $urandom;
        return t;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        dsel = 0;
        HWDATA = '0;
        drive_idle();
        HRESET = 1'b1;
        repeat (3) @(negedge HCLK);
        HRESET = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("rst_hreadyout", {31'b0, hro[d]}, 1);
            chk("rst_hresp", {31'b0, hresp[d]}, 0);
            chk("rst_hrdata", hrd[d], 0);
        end

        // Fill both memories so every later read has a known expected word.
        for (int d = 0; d < 2; d++) begin
            dsel = d;
            for (int w = 0; w < DEPTH; w++) seq.push_back(mk(2'b10, 1'b1, 3'd2, 32'(w * 4), $urandom));
            run_seq();
        end

        // Zero-wait instance: write/read forwarding, byte merge, errors, BUSY.
        dsel = 0;
        seq.push_back(mk(2'b10, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF));
        seq.push_back(mk(2'b10, 1'b0, 3'd2, 32'h10, 32'h0));
        seq.push_back(mk(2'b10, 1'b1, 3'd2, 32'h10, 32'h11223344));
        seq.push_back(mk(2'b10, 1'b1, 3'd0, 32'h13, 32'hAA000000));
        seq.push_back(mk(2'b10, 1'b0, 3'd2, 32'h10, 32'h0));
        seq.push_back(mk(2'b10, 1'b0, 3'd2, 32'h400, 32'h0));
        seq.push_back(mk(2'b10, 1'b0, 3'd2, 32'h10, 32'h0));
        seq.push_back(mk(2'b10, 1'b1, 3'd1, 32'h01, 32'hFFFFFFFF));
        seq.push_back(mk(2'b10, 1'b1, 3'd3, 32'h00, 32'hFFFFFFFF));
        seq.push_back(mk(2'b10, 1'b0, 3'd2, 32'h00, 32'h0));
        seq.push_back(mk(2'b10, 1'b1, 3'd2, 32'h40, 32'h01020304));
        seq.push_back(mk(2'b01, 1'b1, 3'd2, 32'h44, 32'h0));
        seq.push_back(mk(2'b11, 1'b1, 3'd2, 32'h44, 32'h05060708));
        seq.push_back(mk(2'b00, 1'b0, 3'd2, 32'h48, 32'h0));
        seq.push_back(mk(2'b10, 1'b0, 3'd2, 32'h40, 32'h0));
        seq.push_back(mk(2'b10, 1'b0, 3'd2, 32'h44, 32'h0));
        run_seq();
        chk("byte_merge", model[0][4], 32'hAA223344);

        // Three-wait instance: INCR4 writes then reads, then a fault mix.
        dsel = 1;
        for (int i = 0; i < 4; i++) seq.push_back(mk(i == 0 ? 2'b10 : 2'b11, 1'b1, 3'd2, 32'(32'h20 + 4 * i), $urandom));
        for (int i = 0; i < 4; i++) seq.push_back(mk(i == 0 ? 2'b10 : 2'b11, 1'b0, 3'd2, 32'(32'h20 + 4 * i), 32'h0));
        seq.push_back(mk(2'b10, 1'b0, 3'd2, 32'h400, 32'h0));
        seq.push_back(mk(2'b10, 1'b1, 3'd1, 32'h22, 32'hBEEF0000));
        seq.push_back(mk(2'b10, 1'b0, 3'd2, 32'h20, 32'h0));
        run_seq();

        // Randomised traffic on both instances.
        for (int d = 0; d < 2; d++) begin
            dsel = d;
            for (int i = 0; i < 300; i++) seq.push_back(rnd_xfer());
            run_seq();
        end

        // Reset while a write sits in its wait states: the write must vanish.
        dsel = 1;
        @(negedge HCLK);
        bus_sel = 1'b1; HTRANS = 2'b10; HADDR = 32'h60; HWRITE = 1'b1; HSIZE = 3'd2;
        @(negedge HCLK);
        HWDATA = ~model[1][24];
        drive_idle();
        chk("rst_mid_stall", {31'b0, hro[1]}, 0);
        HRESET = 1'b1;
        @(negedge HCLK);
        HRESET = 1'b0;
        chk("rst_mid_hreadyout", {31'b0, hro[1]}, 1);
        chk("rst_mid_hresp", {31'b0, hresp[1]}, 0);
        chk("rst_mid_hrdata", hrd[1], 0);
        seq.push_back(mk(2'b10, 1'b0, 3'd2, 32'h60, 32'h0));
        run_seq();

        repeat (2) @(negedge HCLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
